// File: rtl/box_overlay_pkg.sv
// Shared video parameters for the box overlay: pixel width, box colour table
// and the commit state encoding.
package box_overlay_pkg;

  localparam int PIX_W = 24;

  localparam logic [PIX_W-1:0] BOX_COLOR [8] = '{
    24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
    24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF
  };

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } commit_state_t;

endpackage

// File: rtl/box_overlay_hit.sv
// Combinational border test of one box against the current pixel.
// Arithmetic is widened by 4 bits so bound + LINE_W can never wrap.
module box_hit #(
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12,
  parameter int LINE_W = 2
) (
  input  logic              i_en,
  input  logic [X_BITS-1:0] i_x0,
  input  logic [X_BITS-1:0] i_x1,
  input  logic [Y_BITS-1:0] i_y0,
  input  logic [Y_BITS-1:0] i_y1,
  input  logic [X_BITS-1:0] i_x,
  input  logic [Y_BITS-1:0] i_y,
  output logic              o_hit
);
  localparam int XW = X_BITS + 4;
  localparam int YW = Y_BITS + 4;
  localparam logic [XW-1:0] LW_X = XW'(LINE_W);
  localparam logic [YW-1:0] LW_Y = YW'(LINE_W);

  logic [XW-1:0] w_x, w_x0, w_x1;
  logic [YW-1:0] w_y, w_y0, w_y1;
  logic          w_valid, w_inside, w_edge;

  assign w_x  = XW'(i_x);
  assign w_x0 = XW'(i_x0);
  assign w_x1 = XW'(i_x1);
  assign w_y  = YW'(i_y);
  assign w_y0 = YW'(i_y0);
  assign w_y1 = YW'(i_y1);

  assign w_valid  = i_en && (w_x0 <= w_x1) && (w_y0 <= w_y1);
  assign w_inside = (w_x >= w_x0) && (w_x <= w_x1) && (w_y >= w_y0) && (w_y <= w_y1);
  // Boxes thinner than two borders fall through to solid fill here.
  assign w_edge   = (w_x < w_x0 + LW_X) || (w_x + LW_X > w_x1) ||
                    (w_y < w_y0 + LW_Y) || (w_y + LW_Y > w_y1);

  assign o_hit = w_valid && w_inside && w_edge;

endmodule

// File: rtl/box_overlay.sv
// Draws up to NBOX rectangle borders over an RGB888 stream. Box registers are
// double-buffered; a commit is applied at the next rising edge of vs_in.
module box_overlay
  import box_overlay_pkg::*;
#(
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12,
  parameter int NBOX   = 4,
  parameter int LINE_W = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              de_in,
  input  logic [X_BITS-1:0] x_act,
  input  logic [Y_BITS-1:0] y_act,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [2:0]        wr_idx,
  input  logic              wr_en,
  input  logic [X_BITS-1:0] wr_x0,
  input  logic [X_BITS-1:0] wr_x1,
  input  logic [Y_BITS-1:0] wr_y0,
  input  logic [Y_BITS-1:0] wr_y1,
  input  logic              commit,
  output logic              vs_out,
  output logic              hs_out,
  output logic              de_out,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pending
);
  commit_state_t     r_state, w_state_nxt;
  logic              r_vs_prev, w_vs_rise, w_copy, w_wr;

  logic              r_wen [NBOX];
  logic              r_sen [NBOX];
  logic [X_BITS-1:0] r_wx0 [NBOX], r_wx1 [NBOX], r_sx0 [NBOX], r_sx1 [NBOX];
  logic [Y_BITS-1:0] r_wy0 [NBOX], r_wy1 [NBOX], r_sy0 [NBOX], r_sy1 [NBOX];

  logic [NBOX-1:0]   w_hit, r_hit1;
  logic              r_vs1, r_hs1, r_de1;
  logic [PIX_W-1:0]  r_pix1, w_pix_sel;

  assign w_vs_rise = vs_in & ~r_vs_prev;
  assign wr_ready  = rstn & ~w_copy;
  assign w_wr      = wr_valid & wr_ready;
  assign pending   = (r_state == ST_ARMED);

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A commit landing on the vs edge only arms; the copy waits a frame.
  always_comb begin
    w_state_nxt = r_state;
    w_copy      = 1'b0;
    case (r_state)
      ST_IDLE:  if (commit) w_state_nxt = ST_ARMED;
      ST_ARMED: if (w_vs_rise) begin
        w_state_nxt = ST_IDLE;
        w_copy      = 1'b1;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_vs_prev <= 1'b0;
      for (int i = 0; i < NBOX; i++) begin
        r_wen[i] <= 1'b0; r_wx0[i] <= '0; r_wx1[i] <= '0; r_wy0[i] <= '0; r_wy1[i] <= '0;
        r_sen[i] <= 1'b0; r_sx0[i] <= '0; r_sx1[i] <= '0; r_sy0[i] <= '0; r_sy1[i] <= '0;
      end
    end else begin
      r_vs_prev <= vs_in;
      for (int i = 0; i < NBOX; i++) begin
        if (w_wr && (wr_idx == 3'(i))) begin
          r_wen[i] <= wr_en;
          r_wx0[i] <= wr_x0;
          r_wx1[i] <= wr_x1;
          r_wy0[i] <= wr_y0;
          r_wy1[i] <= wr_y1;
        end
        if (w_copy) begin
          r_sen[i] <= r_wen[i];
          r_sx0[i] <= r_wx0[i];
          r_sx1[i] <= r_wx1[i];
          r_sy0[i] <= r_wy0[i];
          r_sy1[i] <= r_wy1[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NBOX; g++) begin : g_box
    box_hit #(.X_BITS(X_BITS), .Y_BITS(Y_BITS), .LINE_W(LINE_W)) u_hit (
      .i_en (r_sen[g]),
      .i_x0 (r_sx0[g]),
      .i_x1 (r_sx1[g]),
      .i_y0 (r_sy0[g]),
      .i_y1 (r_sy1[g]),
      .i_x  (x_act),
      .i_y  (y_act),
      .o_hit(w_hit[g])
    );
  end

  // Walk downward so the lowest hitting index wins.
  always_comb begin
    w_pix_sel = r_pix1;
    for (int i = NBOX - 1; i >= 0; i--) begin
      if (r_hit1[i]) w_pix_sel = BOX_COLOR[3'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_hit1  <= '0;
      r_vs1   <= 1'b0;
      r_hs1   <= 1'b0;
      r_de1   <= 1'b0;
      r_pix1  <= '0;
      vs_out  <= 1'b0;
      hs_out  <= 1'b0;
      de_out  <= 1'b0;
      pix_out <= '0;
    end else begin
      r_hit1  <= w_hit;
      r_vs1   <= vs_in;
      r_hs1   <= hs_in;
      r_de1   <= de_in;
      r_pix1  <= pix_in;
      vs_out  <= r_vs1;
      hs_out  <= r_hs1;
      de_out  <= r_de1;
      pix_out <= r_de1 ? w_pix_sel : '0;
    end
  end

endmodule

// File: tb/tb_box_overlay.sv
// Randomised frame-level bench for box_overlay against a behavioural model of
// the box registers, the commit rule and the border/priority rule.
module tb_box_overlay;
  localparam int XB = 12, YB = 12, NB = 4, LW = 2;
  localparam int AW = 48, AH = 48, HT = 56, VT = 52;

  logic        clk = 1'b0;
  logic        rstn, vs_in, hs_in, de_in;
  logic [11:0] x_act, y_act;
  logic [23:0] pix_in;
  logic        wr_valid, wr_ready, wr_en, commit;
  logic [2:0]  wr_idx;
  logic [11:0] wr_x0, wr_x1, wr_y0, wr_y1;
  logic        vs_out, hs_out, de_out, pending;
  logic [23:0] pix_out;

  always #5 clk = ~clk;

  box_overlay #(.X_BITS(XB), .Y_BITS(YB), .NBOX(NB), .LINE_W(LW)) dut (
    .clk(clk), .rstn(rstn), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .x_act(x_act), .y_act(y_act), .pix_in(pix_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_en(wr_en),
    .wr_x0(wr_x0), .wr_x1(wr_x1), .wr_y0(wr_y0), .wr_y1(wr_y1),
    .commit(commit), .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
    .pix_out(pix_out), .pending(pending)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {int en; int x0; int y0; int x1; int y1;} box_t;
  typedef struct {bit vs; bit hs; bit de; logic [23:0] pix; logic [23:0] pin; int x; int y; int fr;} stg_t;

  box_t wk [NB];
  box_t sh [NB];
  bit   m_armed, m_vs_prev, accepted, const_pix;
  stg_t m_s1, m_out;
  int   hc = 0, vc = 0, fr = 0;

  function automatic logic [23:0] color_of(int i);
    case (i)
      0: return 24'hFF0000;
      1: return 24'h00FF00;
      2: return 24'h0000FF;
      3: return 24'hFFFF00;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  function automatic logic [23:0] ref_pix(int x, int y, logic [23:0] p);
    for (int i = 0; i < NB; i++) begin
      box_t b;
      b = sh[i];
      if (b.en != 0 && b.x0 <= b.x1 && b.y0 <= b.y1 &&
          x >= b.x0 && x <= b.x1 && y >= b.y0 && y <= b.y1 &&
          (x < b.x0 + LW || x + LW > b.x1 || y < b.y0 + LW || y + LW > b.y1))
        return color_of(i);
    end
    return p;
  endfunction

  // Directed spot pixels of known colour, keyed by frame number.
  task automatic spot(stg_t e);
    if (!e.de) return;
    if (e.fr == 1 && e.y > 6 && e.x == 10 && e.y == 15)
      chk("shadow_hold", 32'(pix_out), 32'(e.pin));
    if (e.fr == 2) begin
      if (((e.x == 10 || e.x == 11 || e.x == 19) && e.y == 15) || (e.x == 15 && e.y == 20))
        chk("box0_border", 32'(pix_out), 32'h00FF0000);
      if ((e.x == 12 || e.x == 21) && e.y == 15)
        chk("box0_pass", 32'(pix_out), 32'(e.pin));
    end
    if (e.fr == 3) begin
      if (e.x == 10 && e.y == 15) chk("late_old_box", 32'(pix_out), 32'h00FF0000);
      if (e.x == 0 && e.y == 0)   chk("late_no_copy", 32'(pix_out), 32'(e.pin));
    end
    if (e.fr == 4) begin
      if (e.x == 0 && e.y == 0) chk("prio_red", 32'(pix_out), 32'h00FF0000);
      if (e.x >= 40 && e.x <= 42 && e.y >= 40 && e.y <= 42)
        chk("solid_small", 32'(pix_out), 32'h00FFFF00);
      if ((e.x == 30 || e.x == 29) && e.y == 30) chk("degenerate", 32'(pix_out), 32'(e.pin));
      if ((e.x == 10 && e.y == 15) || (e.x == 2 && e.y == 2))
        chk("moved_pass", 32'(pix_out), 32'(e.pin));
    end
  endtask

  task automatic cycle();
    stg_t cur;
    bit   rise, exp_rdy;
    de_in  = (hc < AW) && (vc < AH);
    hs_in  = (hc >= 50) && (hc < 54);
    vs_in  = (vc >= 50);
    x_act  = de_in ? 12'(hc) : 12'($urandom);
    y_act  = de_in ? 12'(vc) : 12'($urandom);
    pix_in = const_pix ? 24'h123456 : 24'($urandom);
    #1;
    rise    = vs_in && !m_vs_prev;
    exp_rdy = rstn && !(m_armed && rise);
    chk("wr_ready", 32'(wr_ready), 32'(exp_rdy));
    accepted = wr_valid && exp_rdy;
    cur.vs = vs_in; cur.hs = hs_in; cur.de = de_in; cur.pin = pix_in;
    cur.pix = de_in ? ref_pix(hc, vc, pix_in) : 24'h0;
    cur.x = hc; cur.y = vc; cur.fr = fr;
    @(posedge clk);
    if (!rstn) begin
      for (int i = 0; i < NB; i++) begin
        wk[i] = '{0, 0, 0, 0, 0};
        sh[i] = '{0, 0, 0, 0, 0};
      end
      m_armed = 0; m_vs_prev = 0;
      m_s1 = '{default: 0}; m_out = '{default: 0};
    end else begin
      if (accepted && int'(wr_idx) < NB)
        wk[int'(wr_idx)] = '{int'(wr_en), int'(wr_x0), int'(wr_y0), int'(wr_x1), int'(wr_y1)};
      if (m_armed && rise) begin
        sh = wk;
        m_armed = 0;
      end else if (!m_armed && commit) m_armed = 1;
      m_vs_prev = vs_in;
      m_out = m_s1;
      m_s1  = cur;
    end
    #1;
    chk("vs_out",  32'(vs_out),  32'(m_out.vs));
    chk("hs_out",  32'(hs_out),  32'(m_out.hs));
    chk("de_out",  32'(de_out),  32'(m_out.de));
    chk("pix_out", 32'(pix_out), 32'(m_out.pix));
    chk("pending", 32'(pending), 32'(m_armed));
    spot(m_out);
    hc++;
    if (hc == HT) begin
      hc = 0; vc++;
      if (vc == VT) begin vc = 0; fr++; end
    end
  endtask

  task automatic run_to(int f, int v, int h);
    int n = 0;
    while (!(fr == f && vc == v && hc == h) && n < 20000) begin
      cycle();
      n++;
    end
    chk("run_to", 32'(fr == f && vc == v && hc == h), 32'd1);
  endtask

  task automatic write_box(int idx, bit en, int x0, int y0, int x1, int y1);
    bit done = 0;
    wr_idx = 3'(idx); wr_en = en;
    wr_x0 = 12'(x0); wr_y0 = 12'(y0); wr_x1 = 12'(x1); wr_y1 = 12'(y1);
    wr_valid = 1'b1;
    for (int k = 0; k < 4 && !done; k++) begin
      cycle();
      done = accepted;
    end
    wr_valid = 1'b0;
    chk("wr_accept", 32'(done), 32'd1);
  endtask

  task automatic do_commit();
    commit = 1'b1;
    cycle();
    commit = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; commit = 1'b0; wr_valid = 1'b0; wr_idx = '0; wr_en = 1'b0;
    wr_x0 = '0; wr_x1 = '0; wr_y0 = '0; wr_y1 = '0; const_pix = 1'b1;
    m_armed = 0; m_vs_prev = 0; m_s1 = '{default: 0}; m_out = '{default: 0};
    for (int i = 0; i < NB; i++) begin wk[i] = '{0, 0, 0, 0, 0}; sh[i] = '{0, 0, 0, 0, 0}; end
    repeat (3) cycle();
    rstn = 1'b1; hc = 0; vc = 0; fr = 0;

    run_to(1, 0, 0);
    const_pix = 1'b0;
    run_to(1, 5, 3);
    write_box(0, 1, 10, 10, 20, 20);
    do_commit();

    run_to(2, 3, 0);
    write_box(0, 1, 0, 0, 5, 5);
    write_box(1, 1, 0, 0, 5, 5);
    write_box(5, 1, 0, 0, 47, 47);
    write_box(2, 1, 30, 0, 29, 47);
    write_box(3, 1, 40, 40, 42, 42);
    run_to(2, 50, 0);
    do_commit();
    chk("commit_on_vs", 32'(pending), 32'd1);

    run_to(5, 10, 0);
    write_box(0, 1, 5, 5, 25, 25);
    do_commit();
    run_to(5, 20, 10);
    rstn = 1'b0;
    repeat (2) cycle();
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_pix", 32'(pix_out), 32'd0);
    rstn = 1'b1;

    for (int f = 7; f < 10; f++) begin
      run_to(f, $urandom_range(0, 30), $urandom_range(0, 40));
      repeat (3) begin
        int a, b, c, d;
        a = $urandom_range(0, 50); b = $urandom_range(0, 50);
        c = $urandom_range(0, 50); d = $urandom_range(0, 50);
        write_box($urandom_range(0, 7), 1'($urandom_range(0, 3) != 0), a, b, c, d);
        repeat ($urandom_range(0, 5)) cycle();
      end
      if ($urandom_range(0, 3) != 0) do_commit();
    end
    run_to(10, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/box_overlay.md
BOX_OVERLAY -- requirements
Module: box_overlay

Interface
REQ-001 SHALL have parameter X_BITS, default 12, horizontal coordinate width.
REQ-002 SHALL have parameter Y_BITS, default 12, vertical coordinate width.
REQ-003 SHALL have parameter NBOX, default 4, number of boxes, at most 8.
REQ-004 SHALL have parameter LINE_W, default 2, border thickness in pixels, range 1..15.
REQ-005 SHALL have ports, in order:
- clk  in  1  pixel clock
- rstn  in  1  reset, synchronous, active-low
- vs_in, hs_in, de_in  in  1 each  timing strobes from the timing generator; vs/hs active-high
- x_act  in  X_BITS  active pixel column
- y_act  in  Y_BITS  active pixel row
- pix_in  in  24  RGB888 video pixel
- wr_valid  in  1  box-write request
- wr_ready  out  1  box-write accept
- wr_idx  in  3  box index
- wr_en  in  1  box enable
- wr_x0, wr_x1  in  X_BITS each  box left and right bounds, inclusive
- wr_y0, wr_y1  in  Y_BITS each  box top and bottom bounds, inclusive
- commit  in  1  single-cycle pulse requesting a shadow update
- vs_out, hs_out, de_out  out  1 each  delayed timing strobes
- pix_out  out  24  overlaid pixel
- pending  out  1  commit waiting for the next frame

Function
REQ-006 SHALL hold two register sets per box: working and shadow (en, x0, y0, x1, y1).
REQ-007 SHALL perform a write on the cycle where wr_valid and wr_ready are both high.
- The write loads the working set at wr_idx.
- Writes with wr_idx >= NBOX are accepted and discarded.
REQ-008 SHALL drive wr_ready high in every cycle except the shadow-copy cycle (REQ-011).
REQ-009 SHALL implement the commit state machine IDLE -> ARMED -> IDLE.
- A commit pulse moves IDLE to ARMED.
- A commit pulse while already ARMED has no additional effect.
- pending is high exactly while the state is ARMED.
REQ-010 SHALL detect the frame boundary as the rising edge of vs_in, using the registered previous value of vs_in.
REQ-011 SHALL handle a vs_in rising edge while ARMED as follows:
- Copy all working sets into the shadow sets in that same cycle.
- Return to IDLE.
- Hold wr_ready low for that one cycle.
REQ-012 SHALL, when a commit pulse and a vs_in rising edge coincide in IDLE, move to ARMED without copying; the copy occurs at the next frame.
REQ-013 SHALL use only the shadow sets for drawing, so that no box changes within a frame.
REQ-014 SHALL classify pixel (x, y) as a border pixel of box i when all of the following hold:
- shadow en is 1, x0<=x1 and y0<=y1;
- x0<=x<=x1 and y0<=y<=y1;
- x<x0+LINE_W, or x+LINE_W>x1, or y<y0+LINE_W, or y+LINE_W>y1.
REQ-015 SHALL evaluate all REQ-014 comparisons at X_BITS+4 or Y_BITS+4 bits, so that sums never wrap. A box narrower than 2*LINE_W is therefore filled solid.
REQ-016 SHALL give box priority to the lowest index when several boxes hit the same pixel.
REQ-017 SHALL output the hit box's colour from BOX_COLOR[i] when de is high and a box hits; otherwise pix_in passes through delayed.
REQ-018 SHALL output 24'h000000 on pix_out whenever the delayed de_out is low.
REQ-019 SHALL have a fixed latency of 2 clocks from vs_in, hs_in, de_in and pix_in to vs_out, hs_out, de_out and pix_out.
- Stage 1 registers the hit vector and delays the strobes and pixel.
- Stage 2 registers the priority mux.

Reset
REQ-020 SHALL, while rstn is low at a clock edge, clear the following:
- all working and shadow en bits to 0, and all bounds to 0;
- state to IDLE, pending to 0;
- vs_out, hs_out and de_out to 0, and pix_out to 0;
- both pipeline stages, and the previous-vs register to 0.
REQ-021 SHALL drive wr_ready to 0 during reset and to 1 on the first cycle after reset.
REQ-022 SHALL, when reset is applied mid-frame or while ARMED, discard the pending commit. After release the output stays pass-through until a new commit is taken at a vs edge.

Structure
REQ-023 SHALL place the BOX_COLOR table (8 x 24-bit, index 0 = 24'hFF0000, index 1 = 24'h00FF00, index 2 = 24'h0000FF, index 3 = 24'hFFFF00, indices 4..7 = 24'hFFFFFF) and the 24-bit pixel-width constant in the shared video parameter package.
REQ-024 SHALL instantiate NBOX copies of one sub-module, box_hit. box_hit is purely combinational, takes the shadow set plus x and y, and returns the REQ-014 hit bit.

Verification
REQ-025 Timing: pix_in=24'h123456 constant, no boxes enabled -> pix_out equals pix_in exactly 2 clocks later whenever de_out is high, and 0 when de_out is low; strobes are delayed by 2 clocks.
REQ-026 Single box: box0 = (10,10)-(20,20), enabled, LINE_W=2, committed, then one vs edge.
- Pixels (10,15), (11,15), (19,15) and (15,20) -> 24'hFF0000.
- Pixels (12,15) and (21,15) -> pass through.
REQ-027 Shadowing: write box0 and commit in mid-frame -> the current frame is unchanged, pending=1, and the box appears from the frame after the vs edge; pending=0 and wr_ready=0 for exactly that one cycle.
REQ-028 Priority and degenerate boxes:
- Overlapping box0 (0,0)-(5,5) and box1 (0,0)-(5,5) -> red.
- Box with x0=30, x1=29 -> never drawn.
- Box (40,40)-(42,42) with LINE_W=2 -> all 9 pixels coloured.
REQ-029 Boundary case: commit pulse in the same cycle as the vs rising edge -> no copy; the copy happens at the following vs edge. wr_idx=5 with NBOX=4 -> accepted and no register changes.
REQ-030 Reset case: assert rstn=0 while ARMED and mid-line -> all outputs 0 and pending=0; after release, pix_out passes through until a new commit is taken.
